// File: rtl/store_buffer_pkg.sv
// rtl/store_buffer_pkg.sv - shared types and constants for the store buffer
package store_buffer_pkg;

  // Memory access type encoding carried with each store
  localparam logic [1:0] MT_NONE = 2'b00;
  localparam logic [1:0] MT_BYTE = 2'b01;
  localparam logic [1:0] MT_HALF = 2'b10;
  localparam logic [1:0] MT_WORD = 2'b11;

  // Data-memory word index slice used for load/store overlap checks
  localparam int WIDX_HI = 13;
  localparam int WIDX_LO = 2;
  localparam int WIDX_W  = WIDX_HI - WIDX_LO + 1;

  // One queued store
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  mtype;
  } sb_entry_t;

  function automatic logic [WIDX_W-1:0] word_idx(input logic [31:0] a);
    return a[WIDX_HI:WIDX_LO];
  endfunction

endpackage

// File: rtl/store_buffer_sb_match.sv
// rtl/store_buffer_sb_match.sv - DEPTH-way word comparator with youngest-match priority
module store_buffer_sb_match
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic [DEPTH-1:0][WIDX_W-1:0] entry_idx,
  input  logic [PTR_W-1:0]             rd_ptr,
  input  logic [PTR_W:0]               count,
  input  logic [WIDX_W-1:0]            ld_idx,
  output logic                         hit,
  output logic [PTR_W-1:0]             hit_idx
);

  logic [PTR_W-1:0] slot;

  // Walk entries oldest to youngest so the last valid match wins
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    slot    = rd_ptr;
    for (int a = 0; a < DEPTH; a++) begin
      slot = rd_ptr + a[PTR_W-1:0];
      if (((PTR_W+1)'(a) < count) && (entry_idx[slot] == ld_idx)) begin
        hit     = 1'b1;
        hit_idx = slot;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - store queue owning the data-memory port (optional forwarding: STORE_BUF_FWD_EN)
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        st_req,
  input  logic [31:0] st_pc,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [1:0]  st_type,
  output logic        st_full,
  input  logic        ld_req,
  input  logic [31:0] ld_addr,
  output logic        ld_hazard,
  output logic        ld_fwd_valid,
  output logic [31:0] ld_fwd_data,
  output logic        dm_scr,
  output logic [31:0] dm_pc,
  output logic [1:0]  dm_type,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_din,
  output logic        sb_empty
);

  sb_entry_t mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             enq;
  logic             deq;
  logic             hit;
  logic [PTR_W-1:0] hit_idx;
  logic             fwd_ok;
  logic             load_go;
  logic [DEPTH-1:0][WIDX_W-1:0] entry_idx;

  assign st_full  = (count == (PTR_W+1)'(DEPTH));
  assign sb_empty = (count == '0);
  assign enq      = !reset && st_req && (st_type != MT_NONE) && !st_full;
  assign deq      = dm_scr;

  // Expose each entry's word index to the comparator
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_idx[i] = word_idx(mem[i].addr);
    end
  end

  store_buffer_sb_match #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_match (
    .entry_idx (entry_idx),
    .rd_ptr    (rd_ptr),
    .count     (count),
    .ld_idx    (word_idx(ld_addr)),
    .hit       (hit),
    .hit_idx   (hit_idx)
  );

`ifdef STORE_BUF_FWD_EN
  // Forward only when the youngest overlapping store covers the whole word
  always_comb begin
    fwd_ok       = hit && (mem[hit_idx].mtype == MT_WORD) && (mem[hit_idx].addr[1:0] == 2'b00);
    ld_fwd_valid = ld_req && fwd_ok;
    ld_fwd_data  = ld_fwd_valid ? mem[hit_idx].data : 32'h0;
  end
`else
  // Without forwarding every overlap stalls the load
  always_comb begin
    fwd_ok       = 1'b0;
    ld_fwd_valid = 1'b0;
    ld_fwd_data  = 32'h0;
  end
  logic unused_hit_idx;
  assign unused_hit_idx = ^hit_idx;
`endif

  // Loads own the port unless hazarded; otherwise drain the head
  always_comb begin
    ld_hazard = ld_req && hit && !fwd_ok;
    load_go   = ld_req && !ld_hazard;
    dm_scr    = !reset && !load_go && !sb_empty;
    dm_addr   = dm_scr ? mem[rd_ptr].addr : ld_addr;
    dm_pc     = mem[rd_ptr].pc;
    dm_type   = mem[rd_ptr].mtype;
    dm_din    = mem[rd_ptr].data;
  end

  // Payload storage; not cleared on reset
  always_ff @(posedge clk) begin
    if (enq) begin
      mem[wr_ptr] <= '{st_pc, st_addr, st_data, st_type};
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - directed table-driven bench for store_buffer
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_req;
  logic [31:0] st_pc, st_addr, st_data;
  logic [1:0]  st_type;
  logic        st_full;
  logic        ld_req;
  logic [31:0] ld_addr;
  logic        ld_hazard, ld_fwd_valid;
  logic [31:0] ld_fwd_data;
  logic        dm_scr;
  logic [31:0] dm_pc, dm_addr, dm_din;
  logic [1:0]  dm_type;
  logic        sb_empty;

  int total = 0;
  int bad   = 0;

  store_buffer dut (
    .clk(clk), .reset(reset),
    .st_req(st_req), .st_pc(st_pc), .st_addr(st_addr), .st_data(st_data), .st_type(st_type),
    .st_full(st_full),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_hazard(ld_hazard),
    .ld_fwd_valid(ld_fwd_valid), .ld_fwd_data(ld_fwd_data),
    .dm_scr(dm_scr), .dm_pc(dm_pc), .dm_type(dm_type), .dm_addr(dm_addr), .dm_din(dm_din),
    .sb_empty(sb_empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          sr;
    logic [31:0] sa;
    logic [31:0] sd;
    logic [1:0]  stp;
    bit          lr;
    logic [31:0] la;
    bit          e_full;
    bit          e_empty;
    bit          e_haz;
    bit          e_scr;
    logic [31:0] e_addr;
    logic [31:0] e_din;
    logic [1:0]  e_typ;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(bit sr, logic [31:0] sa, logic [31:0] sd, logic [1:0] stp,
                             bit lr, logic [31:0] la, bit f, bit e, bit h, bit s,
                             logic [31:0] ea, logic [31:0] ed, logic [1:0] et);
    vec_t r;
    r.sr = sr; r.sa = sa; r.sd = sd; r.stp = stp; r.lr = lr; r.la = la;
    r.e_full = f; r.e_empty = e; r.e_haz = h; r.e_scr = s;
    r.e_addr = ea; r.e_din = ed; r.e_typ = et;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input bit sr, input logic [31:0] sa, input logic [31:0] sd,
                       input logic [1:0] stp, input bit lr, input logic [31:0] la);
    st_req = sr; st_addr = sa; st_pc = sa + 32'h1000; st_data = sd; st_type = stp;
    ld_req = lr; ld_addr = la;
  endtask

  task automatic do_reset(input bit with_store);
    @(negedge clk);
    reset = 1'b1;
    drive(with_store, 32'h300, 32'hCAFE0000, 2'b11, 1'b0, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 32'h0);
    #2;
  endtask

  task automatic step(input bit sr, input logic [31:0] sa, input logic [31:0] sd,
                      input logic [1:0] stp, input bit lr, input logic [31:0] la);
    @(negedge clk);
    drive(sr, sa, sd, stp, lr, la);
    #2;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 32'h0);
    repeat (2) @(negedge clk);
    do_reset(1'b1);
    check("rst sb_empty", 32'(sb_empty), 32'd1);
    check("rst st_full", 32'(st_full), 32'd0);
    check("rst dm_scr", 32'(dm_scr), 32'd0);
    check("rst ld_hazard", 32'(ld_hazard), 32'd0);
    check("rst ld_fwd_valid", 32'(ld_fwd_valid), 32'd0);
    check("rst ld_fwd_data", ld_fwd_data, 32'd0);

    // sr sa sd stp lr la | full empty haz scr addr din typ
    vecs.push_back(v(1, 32'h10, 32'hDEADBEEF, 2'b11, 0, 32'h0,   0, 1, 0, 0, 32'h0,  32'h0, 2'b00));
    vecs.push_back(v(0, 32'h0,  32'h0,        2'b00, 0, 32'h0,   0, 0, 0, 1, 32'h10, 32'hDEADBEEF, 2'b11));
    vecs.push_back(v(0, 32'h0,  32'h0,        2'b00, 0, 32'h0,   0, 1, 0, 0, 32'h0,  32'h0, 2'b00));
    vecs.push_back(v(1, 32'h0,  32'hA0, 2'b01, 1, 32'h100, 0, 1, 0, 0, 32'h100, 32'h0, 2'b00));
    vecs.push_back(v(1, 32'h4,  32'hA1, 2'b01, 1, 32'h100, 0, 0, 0, 0, 32'h100, 32'h0, 2'b00));
    vecs.push_back(v(1, 32'h8,  32'hA2, 2'b01, 1, 32'h100, 0, 0, 0, 0, 32'h100, 32'h0, 2'b00));
    vecs.push_back(v(1, 32'hC,  32'hA3, 2'b01, 1, 32'h100, 0, 0, 0, 0, 32'h100, 32'h0, 2'b00));
    vecs.push_back(v(1, 32'h14, 32'hA4, 2'b01, 1, 32'h100, 1, 0, 0, 0, 32'h100, 32'h0, 2'b00));
    vecs.push_back(v(0, 32'h0,  32'h0,  2'b00, 1, 32'h100, 1, 0, 0, 0, 32'h100, 32'h0, 2'b00));
    vecs.push_back(v(0, 32'h0,  32'h0,  2'b00, 0, 32'h0,   1, 0, 0, 1, 32'h0, 32'hA0, 2'b01));
    vecs.push_back(v(0, 32'h0,  32'h0,  2'b00, 0, 32'h0,   0, 0, 0, 1, 32'h4, 32'hA1, 2'b01));
    vecs.push_back(v(0, 32'h0,  32'h0,  2'b00, 0, 32'h0,   0, 0, 0, 1, 32'h8, 32'hA2, 2'b01));
    vecs.push_back(v(0, 32'h0,  32'h0,  2'b00, 0, 32'h0,   0, 0, 0, 1, 32'hC, 32'hA3, 2'b01));
    vecs.push_back(v(0, 32'h0,  32'h0,  2'b00, 0, 32'h0,   0, 1, 0, 0, 32'h0, 32'h0, 2'b00));
    vecs.push_back(v(1, 32'h21, 32'h55, 2'b01, 0, 32'h0,   0, 1, 0, 0, 32'h0, 32'h0, 2'b00));
    vecs.push_back(v(0, 32'h0,  32'h0,  2'b00, 1, 32'h20,  0, 0, 1, 1, 32'h21, 32'h55, 2'b01));
    vecs.push_back(v(0, 32'h0,  32'h0,  2'b00, 1, 32'h20,  0, 1, 0, 0, 32'h20, 32'h0, 2'b00));
    vecs.push_back(v(1, 32'h200, 32'h1, 2'b11, 1, 32'h100, 0, 1, 0, 0, 32'h100, 32'h0, 2'b00));
    vecs.push_back(v(1, 32'h204, 32'h2, 2'b11, 1, 32'h100, 0, 0, 0, 0, 32'h100, 32'h0, 2'b00));
    vecs.push_back(v(1, 32'h208, 32'h3, 2'b11, 1, 32'h100, 0, 0, 0, 0, 32'h100, 32'h0, 2'b00));
    vecs.push_back(v(1, 32'h20C, 32'h4, 2'b11, 1, 32'h100, 0, 0, 0, 0, 32'h100, 32'h0, 2'b00));
    vecs.push_back(v(1, 32'h210, 32'h5, 2'b11, 0, 32'h0,   1, 0, 0, 1, 32'h200, 32'h1, 2'b11));
    vecs.push_back(v(1, 32'h210, 32'h5, 2'b11, 1, 32'h100, 0, 0, 0, 0, 32'h100, 32'h0, 2'b00));
    vecs.push_back(v(0, 32'h0,   32'h0, 2'b00, 1, 32'h100, 1, 0, 0, 0, 32'h100, 32'h0, 2'b00));
    vecs.push_back(v(0, 32'h0,   32'h0, 2'b00, 0, 32'h0,   1, 0, 0, 1, 32'h204, 32'h2, 2'b11));
    vecs.push_back(v(0, 32'h0,   32'h0, 2'b00, 0, 32'h0,   0, 0, 0, 1, 32'h208, 32'h3, 2'b11));
    vecs.push_back(v(0, 32'h0,   32'h0, 2'b00, 0, 32'h0,   0, 0, 0, 1, 32'h20C, 32'h4, 2'b11));
    vecs.push_back(v(0, 32'h0,   32'h0, 2'b00, 0, 32'h0,   0, 0, 0, 1, 32'h210, 32'h5, 2'b11));
    vecs.push_back(v(0, 32'h0,   32'h0, 2'b00, 0, 32'h0,   0, 1, 0, 0, 32'h0, 32'h0, 2'b00));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].sr, vecs[i].sa, vecs[i].sd, vecs[i].stp, vecs[i].lr, vecs[i].la);
      check($sformatf("row%0d st_full", i), 32'(st_full), 32'(vecs[i].e_full));
      check($sformatf("row%0d sb_empty", i), 32'(sb_empty), 32'(vecs[i].e_empty));
      check($sformatf("row%0d ld_hazard", i), 32'(ld_hazard), 32'(vecs[i].e_haz));
      check($sformatf("row%0d dm_scr", i), 32'(dm_scr), 32'(vecs[i].e_scr));
      check($sformatf("row%0d dm_addr", i), dm_addr, vecs[i].e_addr);
      check($sformatf("row%0d ld_fwd_valid", i), 32'(ld_fwd_valid), 32'd0);
      if (vecs[i].e_scr) begin
        check($sformatf("row%0d dm_din", i), dm_din, vecs[i].e_din);
        check($sformatf("row%0d dm_pc", i), dm_pc, vecs[i].e_addr + 32'h1000);
        check($sformatf("row%0d dm_type", i), 32'(dm_type), 32'(vecs[i].e_typ));
      end
    end

    // Reset with three stores pending, plus a store offered during reset
    step(1, 32'h400, 32'h11, 2'b11, 1, 32'h100);
    step(1, 32'h404, 32'h22, 2'b11, 1, 32'h100);
    step(1, 32'h408, 32'h33, 2'b11, 1, 32'h100);
    check("pre-rst sb_empty", 32'(sb_empty), 32'd0);
    do_reset(1'b1);
    check("post-rst sb_empty", 32'(sb_empty), 32'd1);
    check("post-rst dm_scr", 32'(dm_scr), 32'd0);
    for (int k = 0; k < 5; k++) begin
      step(0, 32'h0, 32'h0, 2'b00, 0, 32'h0);
      check($sformatf("idle%0d dm_scr", k), 32'(dm_scr), 32'd0);
    end

    // Word store then same-word load
    do_reset(1'b0);
    step(1, 32'h40, 32'h12345678, 2'b11, 1, 32'h100);
    step(0, 32'h0, 32'h0, 2'b00, 1, 32'h40);
`ifdef STORE_BUF_FWD_EN
    check("fwd ld_fwd_valid", 32'(ld_fwd_valid), 32'd1);
    check("fwd ld_fwd_data", ld_fwd_data, 32'h12345678);
    check("fwd ld_hazard", 32'(ld_hazard), 32'd0);
    check("fwd dm_scr", 32'(dm_scr), 32'd0);
`else
    check("nofwd ld_hazard", 32'(ld_hazard), 32'd1);
    check("nofwd ld_fwd_valid", 32'(ld_fwd_valid), 32'd0);
    check("nofwd dm_scr", 32'(dm_scr), 32'd1);
`endif
    check("wordld dm_addr", dm_addr, 32'h40);

    // Younger half store to the same word stalls the load in either build
    do_reset(1'b0);
    step(1, 32'h40, 32'h12345678, 2'b11, 1, 32'h100);
    step(1, 32'h42, 32'hBEEF, 2'b10, 1, 32'h100);
    step(0, 32'h0, 32'h0, 2'b00, 1, 32'h40);
    check("partial ld_hazard", 32'(ld_hazard), 32'd1);
    check("partial ld_fwd_valid", 32'(ld_fwd_valid), 32'd0);
    check("partial dm_scr", 32'(dm_scr), 32'd1);
    check("partial dm_din", dm_din, 32'h12345678);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Queues CPU stores from the memory stage and drains them into the data memory one per cycle.
- Sits directly upstream of the data memory and owns its single address/write port.
- Loads have priority over drains; the block flags load-after-store word hazards so the pipeline stalls.
- Hides store latency behind subsequent non-memory instructions.

Parameters:
- DEPTH, 4, number of queued stores (power of two, ≥2).
- PTR_W, 2, log2(DEPTH).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- st_req  in  1  store issued this cycle.
- st_pc  in  32  PC of store (carried for write trace).
- st_addr  in  32  byte address of store.
- st_data  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- st_type  in  2  01 byte, 10 half, 11 word; 00 = no store.
- st_full  out  1  queue full; a store presented while high is not accepted and the CPU must stall.
- ld_req  in  1  load uses data-memory port this cycle.
- ld_addr  in  32  load byte address.
- ld_hazard  out  1  load word overlaps a queued store; CPU must stall.
- ld_fwd_valid  out  1  forwarded data valid (optional feature).
- ld_fwd_data  out  32  forwarded word (optional feature).
- dm_scr  out  1  data-memory write strobe.
- dm_pc  out  32  head entry PC.
- dm_type  out  2  head entry type.
- dm_addr  out  32  data-memory address (load or head).
- dm_din  out  32  head entry data.
- sb_empty  out  1  queue empty (fence for syscall/eret).

Behaviour:
- Storage: circular FIFO of {pc, addr, data, type}. Write pointer, read pointer, and count registers, count width PTR_W+1. Pointers wrap modulo DEPTH.
- Reset:
  - count, write pointer and read pointer go to 0.
  - sb_empty=1, st_full=0, dm_scr=0, ld_hazard=0, ld_fwd_valid=0, ld_fwd_data=0.
  - Entry payloads are not cleared.
  - A store presented in the reset cycle is discarded.
- Enqueue: on posedge when st_req && st_type!=00 && !st_full. st_full = (count==DEPTH), evaluated from registered count only. There is no same-cycle bypass, so a full queue refuses a store even if it drains that edge.
- Hazard: ld_hazard = ld_req && some valid entry has addr[13:2]==ld_addr[13:2]. Matching is word-granular, regardless of byte lanes. Purely combinational from registered state.
- Port arbitration, all combinational:
  - ld_req && !ld_hazard: dm_addr=ld_addr, dm_scr=0, no drain.
  - Otherwise if !sb_empty: dm_addr=head addr, dm_scr=1.
  - Otherwise: dm_scr=0, dm_addr=ld_addr.
- A hazarded load therefore forces drains until the conflict clears. This guarantees forward progress.
- Dequeue: read pointer advances at the same posedge that dm_scr=1. Write latency through the queue is at least 1 cycle after enqueue; the entry is visible at the head the cycle after acceptance.
- Simultaneous enqueue and dequeue: count is unchanged and both pointers advance.
- sb_empty = (count==0).
- Store ordering is strictly preserved.
- dm_type, dm_din and dm_pc reflect the head entry whenever !sb_empty. They are don't-care otherwise.

Optional Feature:
- Macro: STORE_BUF_FWD_EN.
- Defined:
  - When the youngest matching entry is a word store (type 11) with addr[1:0]==00, ld_fwd_valid=1, ld_fwd_data=that entry's data, and ld_hazard=0. The load proceeds with no stall.
  - A younger partial (byte/half) match still raises ld_hazard.
- Undefined: ld_fwd_valid and ld_fwd_data are tied 0, and every match stalls.

Decomposition:
- Shared package holds:
  - M_type constants: MT_NONE=00, MT_BYTE=01, MT_HALF=10, MT_WORD=11.
  - DM word index slice bounds [13:2].
  - Entry record typedef {pc, addr, data, type}.
- One natural sub-module, sb_match: a DEPTH-way word comparator with youngest-match priority encoder, producing hit and youngest index.

Test Plan:
- Reset, then word store at 0x10 with data 0xDEADBEEF and no loads → next cycle dm_scr=1, dm_addr=0x10, dm_din=0xDEADBEEF; the cycle after, sb_empty=1.
- Store bytes to 0x0, 0x4, 0x8 and 0xC while ld_req is held with ld_addr=0x100 for 6 cycles → no drain and st_full=1 after the 4th store. A 5th store is refused and the queue contents are unchanged. Release ld_req → drains in order 0x0, 0x4, 0x8, 0xC on consecutive cycles.
- Queue a byte store to 0x21, then load ld_addr=0x20 → ld_hazard=1 and dm_scr=1 with dm_addr=0x21. The next cycle ld_hazard=0 and dm_addr=0x20.
- Full queue with drain and st_req in the same cycle → store rejected and count goes to DEPTH-1. The next cycle the store is accepted and count returns to DEPTH.
- Assert reset with 3 entries pending → sb_empty=1 and dm_scr=0 the next cycle, and nothing is written afterwards.
- STORE_BUF_FWD_EN defined: word store 0x12345678 to 0x40, then load 0x40 → ld_fwd_valid=1, ld_fwd_data=0x12345678, ld_hazard=0. Add a half store to 0x42 first, then the load → ld_hazard=1.
